// File: rtl/axi4l_pkg.sv
// ============================================================================
// Module      : axi4l_pkg
// Description : Shared AXI4-lite response encodings and helpers for the
//               read/write slave pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4l_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Any raised collision flag from the core turns the response into SLVERR.
    function automatic resp_t collision_resp(input logic [1:0] coll);
        return (coll != 2'b00) ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi4l_sync_fifo.sv
// ============================================================================
// Module      : axi4l_sync_fifo
// Description : Single-clock first-word fall-through FIFO, depth 2**ASIZE.
//               Extra pointer MSB distinguishes full from empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4l_sync_fifo #(
    parameter int ASIZE = 3,
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wptr_q;
    logic [ASIZE:0]   wptr_d;
    logic [ASIZE:0]   rptr_q;
    logic [ASIZE:0]   rptr_d;
    logic             push;
    logic             pop;

    assign wfull  = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                    (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
    assign rempty = (wptr_q == rptr_q);
    assign push   = winc & ~wfull;
    assign pop    = rinc & ~rempty;
    assign wptr_d = wptr_q + {{ASIZE{1'b0}}, push};
    assign rptr_d = rptr_q + {{ASIZE{1'b0}}, pop};

    // Head entry is always visible; a push into an empty FIFO shows next cycle.
    assign rdata  = mem_q[rptr_q[ASIZE-1:0]];

    // Pointer registers; reset empties the FIFO without clearing storage.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi4l_write.sv
// ============================================================================
// Module      : axi4l_write
// Description : AXI4-lite write slave. Queues AW and W independently, pairs
//               them in order, issues single-cycle core writes and returns
//               one B response per write (SLVERR on core collision).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4l_write
    import axi4l_pkg::*;
#(
    parameter int MAX_OR     = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [1:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    output logic                    wren,
    output logic [ADDR_WIDTH-1:0]   wraddr,
    output logic [DATA_WIDTH-1:0]   wrdata,
    output logic [DATA_WIDTH/8-1:0] wrstrb,
    input  logic [1:0]              wrcollision
);

    localparam int                PTR_W     = $clog2(MAX_OR);
    localparam int                CNT_W     = PTR_W + 1;
    localparam int                STRB_W    = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0]  OUTST_MAX = CNT_W'(MAX_OR);

    logic                         rdy_q;
    logic                         pend_q;
    logic [CNT_W-1:0]             outst_q;
    logic [CNT_W-1:0]             outst_d;

    logic                         aw_full;
    logic                         aw_empty;
    logic                         w_full;
    logic                         w_empty;
    logic                         b_full;
    logic                         b_empty;
    logic [STRB_W+DATA_WIDTH-1:0] w_head;
    resp_t                        b_head;
    logic                         b_pop;

    // awprot carries no meaning here; b_full cannot assert because the
    // outstanding credit bounds B FIFO occupancy.
    logic                         unused_sig;
    assign unused_sig = ^{awprot, b_full};

    // Readies are held low until the first cycle after reset is released.
    assign awready = rdy_q & ~aw_full;
    assign wready  = rdy_q & ~w_full;

    assign wren    = ~aw_empty & ~w_empty & (outst_q < OUTST_MAX);
    assign {wrstrb, wrdata} = w_head;

    assign bvalid  = ~b_empty;
    assign bresp   = b_empty ? RESP_OKAY : b_head;
    assign b_pop   = bvalid & bready;

    axi4l_sync_fifo #(
        .ASIZE (PTR_W),
        .DSIZE (ADDR_WIDTH)
    ) u_aw_fifo (
        .clk    (aclk),
        .srst_n (aresetn),
        .winc   (awvalid & awready),
        .wdata  (awaddr),
        .wfull  (aw_full),
        .rinc   (wren),
        .rdata  (wraddr),
        .rempty (aw_empty)
    );

    axi4l_sync_fifo #(
        .ASIZE (PTR_W),
        .DSIZE (STRB_W + DATA_WIDTH)
    ) u_w_fifo (
        .clk    (aclk),
        .srst_n (aresetn),
        .winc   (wvalid & wready),
        .wdata  ({wstrb, wdata}),
        .wfull  (w_full),
        .rinc   (wren),
        .rdata  (w_head),
        .rempty (w_empty)
    );

    axi4l_sync_fifo #(
        .ASIZE (PTR_W),
        .DSIZE (2)
    ) u_b_fifo (
        .clk    (aclk),
        .srst_n (aresetn),
        .winc   (pend_q),
        .wdata  (collision_resp(wrcollision)),
        .wfull  (b_full),
        .rinc   (b_pop),
        .rdata  (b_head),
        .rempty (b_empty)
    );

    // Outstanding credit: counts writes issued but not yet acknowledged on B.
    always_comb begin
        outst_d = outst_q;
        unique case ({wren, b_pop})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // Ready enable, completion flag and credit counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rdy_q   <= 1'b0;
            pend_q  <= 1'b0;
            outst_q <= '0;
        end else begin
            rdy_q   <= 1'b1;
            pend_q  <= wren;
            outst_q <= outst_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4l_write.sv
// ============================================================================
// Module      : tb_axi4l_write
// Description : Directed self-checking bench for axi4l_write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4l_write;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       awvalid;
    logic       awready;
    logic [2:0] awaddr;
    logic [1:0] awprot;
    logic       wvalid;
    logic       wready;
    logic [7:0] wdata;
    logic [0:0] wstrb;
    logic       bvalid;
    logic       bready;
    logic [1:0] bresp;
    logic       wren;
    logic [2:0] wraddr;
    logic [7:0] wrdata;
    logic [0:0] wrstrb;
    logic [1:0] wrcollision;

    logic [1:0] man_coll  = 2'b00;
    logic [1:0] core_coll = 2'b00;
    logic       core_en   = 1'b0;

    int total = 0;
    int bad   = 0;

    int aw_sent = 0;
    int w_sent  = 0;
    int wr_cnt  = 0;
    int rcnt    = 0;
    int aw_tgt  = 0;
    int w_tgt   = 0;
    int outst   = 0;
    int gaps    = 0;
    int stale   = 0;

    always #5 aclk = ~aclk;

    // Core model: flags a collision the cycle after a write to odd data.
    always @(posedge aclk) begin
        core_coll <= (core_en && wren) ? {1'b0, wrdata[0]} : 2'b00;
    end
    assign wrcollision = man_coll | core_coll;

    axi4l_write #(
        .MAX_OR     (8),
        .ADDR_WIDTH (3),
        .DATA_WIDTH (8)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awprot      (awprot),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .wren        (wren),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .wrstrb      (wrstrb),
        .wrcollision (wrcollision)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [2:0] addr_of(input int i);
        logic [31:0] v;
        v = i;
        return v[2:0] ^ 3'h5;
    endfunction

    function automatic logic [7:0] data_of(input int i);
        logic [31:0] v;
        v = i;
        return 8'h40 + v[7:0];
    endfunction

    function automatic logic [0:0] strb_of(input int i);
        logic [31:0] v;
        v = i;
        return ~v[1];
    endfunction

    function automatic logic [1:0] resp_of(input int i);
        logic [31:0] v;
        v = i;
        return v[0] ? 2'b10 : 2'b00;
    endfunction

    // One cycle of indexed traffic: offer beats, score writes and responses.
    task automatic step();
        awvalid = (aw_sent < aw_tgt);
        awaddr  = addr_of(aw_sent);
        wvalid  = (w_sent < w_tgt);
        wdata   = data_of(w_sent);
        wstrb   = strb_of(w_sent);
        if (wren) begin
            chk("pair_addr", {29'd0, wraddr}, {29'd0, addr_of(wr_cnt)});
            chk("pair_data", {24'd0, wrdata}, {24'd0, data_of(wr_cnt)});
            chk("pair_strb", {31'd0, wrstrb}, {31'd0, strb_of(wr_cnt)});
            wr_cnt++;
            outst++;
        end
        if (bvalid && bready) begin
            chk("b_order", {30'd0, bresp}, {30'd0, resp_of(rcnt)});
            rcnt++;
            outst--;
        end
        if (outst > 8) chk("outst_bound", outst, 8);
        if (awvalid && awready) aw_sent++;
        if (wvalid && wready) w_sent++;
        tick();
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0;
        awaddr  = 3'd0;
        awprot  = 2'b00;
        wvalid  = 1'b0;
        wdata   = 8'd0;
        wstrb   = 1'b0;
        bready  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_awready", {31'd0, awready}, 0);
        chk("rst_wready",  {31'd0, wready},  0);
        chk("rst_bvalid",  {31'd0, bvalid},  0);
        chk("rst_wren",    {31'd0, wren},    0);
        chk("rst_bresp",   {30'd0, bresp},   0);
        aresetn = 1'b1;
        tick();
        chk("rel_awready", {31'd0, awready}, 1);
        chk("rel_wready",  {31'd0, wready},  1);

        // Single write, minimum latency, B held while bready low
        awvalid = 1'b1; awaddr = 3'h5; wvalid = 1'b1; wdata = 8'hA5; wstrb = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("single_wren",   {31'd0, wren},   1);
        chk("single_wraddr", {29'd0, wraddr}, 5);
        chk("single_wrdata", {24'd0, wrdata}, 8'hA5);
        chk("single_wrstrb", {31'd0, wrstrb}, 1);
        tick();
        chk("single_wren_c2", {31'd0, wren},   0);
        chk("single_bv_c2",   {31'd0, bvalid}, 0);
        tick();
        chk("single_bvalid", {31'd0, bvalid}, 1);
        chk("single_bresp",  {30'd0, bresp},  0);
        tick();
        chk("hold_bvalid", {31'd0, bvalid}, 1);
        chk("hold_bresp",  {30'd0, bresp},  0);
        bready = 1'b1;
        tick();
        chk("single_bdone", {31'd0, bvalid}, 0);

        // Collision flagged in cycle 2
        awvalid = 1'b1; awaddr = 3'h2; wvalid = 1'b1; wdata = 8'h3C; wstrb = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("coll_wren", {31'd0, wren}, 1);
        tick();
        man_coll = 2'b01;
        tick();
        man_coll = 2'b00;
        chk("coll_bvalid", {31'd0, bvalid}, 1);
        chk("coll_bresp",  {30'd0, bresp},  2'b10);
        tick();
        chk("coll_bdone", {31'd0, bvalid}, 0);

        // Decoupled channels: AW leads W by several cycles
        for (int i = 0; i < 3; i++) begin
            awvalid = 1'b1; awaddr = 3'(i + 1);
            tick();
        end
        awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("dec_nowren", {31'd0, wren}, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            wvalid = 1'b1; wdata = 8'h11 * 8'(i + 1); wstrb = 1'b1;
            tick();
            chk("dec_wren",   {31'd0, wren},   1);
            chk("dec_wraddr", {29'd0, wraddr}, i + 1);
            chk("dec_wrdata", {24'd0, wrdata}, 32'h11 * (i + 1));
        end
        wvalid = 1'b0;
        tick();
        chk("dec_end_wren", {31'd0, wren}, 0);
        tick(); tick(); tick(); tick();
        chk("dec_drained", {31'd0, bvalid}, 0);

        // Backpressure: 12 writes with bready low, plus 4 extra AW to fill
        core_en = 1'b1;
        bready  = 1'b0;
        aw_tgt  = 16;
        w_tgt   = 12;
        for (int k = 0; k < 30; k++) step();
        chk("bp_wr_cnt",  wr_cnt, 8);
        chk("bp_aw_sent", aw_sent, 16);
        chk("bp_w_sent",  w_sent, 12);
        chk("bp_awready", {31'd0, awready}, 0);
        chk("bp_wready",  {31'd0, wready},  1);
        chk("bp_bvalid",  {31'd0, bvalid},  1);
        chk("bp_bresp",   {30'd0, bresp},   0);
        bready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        chk("drain_wr_cnt", wr_cnt, 12);
        chk("drain_rcnt",   rcnt, 12);
        chk("drain_bvalid", {31'd0, bvalid}, 0);
        chk("drain_awrdy",  {31'd0, awready}, 1);

        // Mid-operation reset with responses queued
        bready = 1'b0;
        w_tgt  = 16;
        for (int k = 0; k < 8; k++) step();
        chk("pre_rst_wr_cnt", wr_cnt, 16);
        chk("pre_rst_bvalid", {31'd0, bvalid}, 1);
        awvalid = 1'b0; wvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        chk("mid_rst_bvalid",  {31'd0, bvalid},  0);
        chk("mid_rst_wren",    {31'd0, wren},    0);
        chk("mid_rst_awready", {31'd0, awready}, 0);
        aresetn = 1'b1;
        tick();
        chk("post_rst_awready", {31'd0, awready}, 1);
        chk("post_rst_wready",  {31'd0, wready},  1);
        bready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (bvalid || wren) stale++;
            tick();
        end
        chk("no_stale", stale, 0);

        // Full throughput: 24 back-to-back writes with bready high
        outst   = 0;
        aw_sent = 16; w_sent = 16; wr_cnt = 16; rcnt = 16;
        aw_tgt  = 40; w_tgt  = 40;
        for (int k = 0; k < 30; k++) begin
            if (k >= 1 && k <= 24 && wren !== 1'b1) gaps++;
            step();
        end
        chk("tp_gaps",   gaps, 0);
        chk("tp_wr_cnt", wr_cnt, 40);
        chk("tp_rcnt",   rcnt, 40);
        chk("tp_outst",  outst, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
